// File: rtl/axi_stream_packet_arb.sv
// Round-robin, packet-locked arbiter: N stream sources share one registered output stream.
// A grant is held from the first accepted beat until the eop beat, so packets never interleave.
module axi_stream_packet_arb #(
   parameter int unsigned NUM_IN   = 2,
   parameter int unsigned DAT_BYTS = 8,
   parameter int unsigned CTL_BITS = 8,
   parameter int unsigned OVR_CTL  = 0,
   localparam int unsigned GRANT_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
   localparam int unsigned MOD_W   = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1,
   localparam int unsigned DAT_W   = DAT_BYTS * 8
) (
   input  logic                               i_clk,
   input  logic                               i_rst,
   input  logic [NUM_IN-1:0]                  i_axi_val,
   output logic [NUM_IN-1:0]                  i_axi_rdy,
   input  logic [NUM_IN-1:0][DAT_W-1:0]       i_axi_dat,
   input  logic [NUM_IN-1:0][CTL_BITS-1:0]    i_axi_ctl,
   input  logic [NUM_IN-1:0][MOD_W-1:0]       i_axi_mod,
   input  logic [NUM_IN-1:0]                  i_axi_sop,
   input  logic [NUM_IN-1:0]                  i_axi_eop,
   input  logic [NUM_IN-1:0]                  i_axi_err,
   output logic                               o_axi_val,
   input  logic                               o_axi_rdy,
   output logic [DAT_W-1:0]                   o_axi_dat,
   output logic [CTL_BITS-1:0]                o_axi_ctl,
   output logic [MOD_W-1:0]                   o_axi_mod,
   output logic                               o_axi_sop,
   output logic                               o_axi_eop,
   output logic                               o_axi_err,
   output logic [GRANT_W-1:0]                 o_grant,
   output logic                               o_locked
);

   typedef enum logic {ST_IDLE, ST_LOCK} state_t;

   state_t               state_q, state_d;
   logic [GRANT_W-1:0]   grant_q, grant_d;
   logic [GRANT_W-1:0]   ptr_q, ptr_d;
   logic                 val_q, val_d;
   logic [DAT_W-1:0]     dat_q, dat_d;
   logic [CTL_BITS-1:0]  ctl_q, ctl_d;
   logic [MOD_W-1:0]     mod_q, mod_d;
   logic                 sop_q, sop_d;
   logic                 eop_q, eop_d;
   logic                 err_q, err_d;

   logic                 win_found;
   logic [GRANT_W-1:0]   win_idx;
   logic [31:0]          cand;
   logic                 out_free;

   // Rotating priority search starting at ptr, wrapping modulo NUM_IN
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         cand = 32'(ptr_q) + i;
         if (cand >= NUM_IN) cand = cand - NUM_IN;
         if (!win_found && i_axi_val[GRANT_W'(cand)]) begin
            win_found = 1'b1;
            win_idx   = GRANT_W'(cand);
         end
      end
   end

   assign out_free = ~val_q | o_axi_rdy;

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      ptr_d     = ptr_q;
      val_d     = val_q;
      dat_d     = dat_q;
      ctl_d     = ctl_q;
      mod_d     = mod_q;
      sop_d     = sop_q;
      eop_d     = eop_q;
      err_d     = err_q;
      i_axi_rdy = '0;

      if (val_q && o_axi_rdy) val_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               grant_d = win_idx;
               state_d = ST_LOCK;
            end
         end
         ST_LOCK: begin
            i_axi_rdy[grant_q] = out_free;
            if (i_axi_val[grant_q] && out_free) begin
               val_d = 1'b1;
               dat_d = i_axi_dat[grant_q];
               ctl_d = i_axi_ctl[grant_q];
               mod_d = i_axi_mod[grant_q];
               sop_d = i_axi_sop[grant_q];
               eop_d = i_axi_eop[grant_q];
               err_d = i_axi_err[grant_q];
               if (OVR_CTL != 0 && NUM_IN > 1) ctl_d[GRANT_W-1:0] = grant_q;
               // Only eop releases the lock; err is just carried along
               if (i_axi_eop[grant_q]) begin
                  state_d = ST_IDLE;
                  ptr_d   = (grant_q == GRANT_W'(NUM_IN - 1)) ? '0 : grant_q + GRANT_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
         val_q   <= 1'b0;
         dat_q   <= '0;
         ctl_q   <= '0;
         mod_q   <= '0;
         sop_q   <= 1'b0;
         eop_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         val_q   <= val_d;
         dat_q   <= dat_d;
         ctl_q   <= ctl_d;
         mod_q   <= mod_d;
         sop_q   <= sop_d;
         eop_q   <= eop_d;
         err_q   <= err_d;
      end
   end

   assign o_axi_val = val_q;
   assign o_axi_dat = dat_q;
   assign o_axi_ctl = ctl_q;
   assign o_axi_mod = mod_q;
   assign o_axi_sop = sop_q;
   assign o_axi_eop = eop_q;
   assign o_axi_err = err_q;
   assign o_grant   = grant_q;
   assign o_locked  = (state_q == ST_LOCK);

endmodule

// File: tb/tb_axi_stream_packet_arb.sv
// Bench for axi_stream_packet_arb (4 inputs, ctl index stamping on): vector table,
// hand-written lock/reset corners, and random traffic against a packet-level model.
module tb_axi_stream_packet_arb;

   logic              clk = 1'b0;
   logic              rst;
   logic [3:0]        in_val, in_rdy, in_sop, in_eop, in_err;
   logic [3:0][63:0]  in_dat;
   logic [3:0][7:0]   in_ctl;
   logic [3:0][2:0]   in_mod;
   logic              out_val, out_rdy, out_sop, out_eop, out_err;
   logic [63:0]       out_dat;
   logic [7:0]        out_ctl;
   logic [2:0]        out_mod;
   logic [1:0]        grant;
   logic              locked;

   int n_chk  = 0;
   int n_fail = 0;

   axi_stream_packet_arb #(.NUM_IN(4), .DAT_BYTS(8), .CTL_BITS(8), .OVR_CTL(1)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_axi_val(in_val), .i_axi_rdy(in_rdy), .i_axi_dat(in_dat), .i_axi_ctl(in_ctl),
      .i_axi_mod(in_mod), .i_axi_sop(in_sop), .i_axi_eop(in_eop), .i_axi_err(in_err),
      .o_axi_val(out_val), .o_axi_rdy(out_rdy), .o_axi_dat(out_dat), .o_axi_ctl(out_ctl),
      .o_axi_mod(out_mod), .o_axi_sop(out_sop), .o_axi_eop(out_eop), .o_axi_err(out_err),
      .o_grant(grant), .o_locked(locked)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] dat;
      logic [7:0]  ctl;
      logic [2:0]  mod;
      logic        sop;
      logic        eop;
      logic        err;
   } beat_t;

   typedef struct packed {
      logic       rst;
      logic [3:0] val;
      logic       sop;
      logic       eop;
      logic [7:0] dat;
      logic       ordy;
      logic       chk_rdy;
      logic [3:0] exp_rdy;
      logic       exp_val;
      logic [1:0] exp_grant;
      logic       exp_locked;
      logic [7:0] exp_dat;
      logic [7:0] exp_ctl;
   } vec_t;

   vec_t  tbl [18];
   beat_t src_q [4][$];
   beat_t exp_q [4][$];
   int    order_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      in_val = '0; in_sop = '0; in_eop = '0; in_err = '0;
      in_dat = '0; in_ctl = '0; in_mod = '0;
   endtask

   task automatic reset_dut(input bit chk);
      rst = 1'b1;
      clear_inputs();
      out_rdy = 1'b0;
      tick();
      tick();
      if (chk) begin
         check("rst_val", 64'(out_val), 64'd0);
         check("rst_dat", out_dat, 64'd0);
         check("rst_ctl", 64'(out_ctl), 64'd0);
         check("rst_mod", 64'(out_mod), 64'd0);
         check("rst_flags", 64'({out_sop, out_eop, out_err}), 64'd0);
         check("rst_grant", 64'(grant), 64'd0);
         check("rst_locked", 64'(locked), 64'd0);
         check("rst_rdy", 64'(in_rdy), 64'd0);
      end
      rst = 1'b0;
   endtask

   // Packet-level traffic: per-source queues, random or fixed timing, output checked beat by beat
   task automatic run_traffic(input int nsrc, input int npkt, input bit rnd);
      int    total, got, cyc, last_eop, cur_src, src, len;
      bit    in_pkt;
      logic [3:0] acc;
      logic  fire;
      beat_t ob, eb, b;
      total = 0; got = 0; cyc = 0; last_eop = -1; cur_src = 0; in_pkt = 1'b0;
      order_q.delete();
      for (int s = 0; s < 4; s++) begin
         src_q[s].delete();
         exp_q[s].delete();
      end
      for (int s = 0; s < nsrc; s++) begin
         for (int p = 0; p < npkt; p++) begin
            len = rnd ? int'($urandom_range(1, 6)) : 2;
            for (int k = 0; k < len; k++) begin
               b.dat = {8'(s), 8'(p), 8'(k), 8'h5A, 32'($urandom)};
               b.ctl = rnd ? 8'($urandom) : 8'(s << 4);
               b.mod = 3'($urandom);
               b.sop = (k == 0);
               b.eop = (k == len - 1);
               b.err = rnd && ($urandom_range(0, 9) == 0);
               src_q[s].push_back(b);
               b.ctl[1:0] = 2'(s);
               exp_q[s].push_back(b);
               total++;
            end
         end
      end
      while (got < total && cyc < 20000) begin
         for (int s = 0; s < nsrc; s++) begin
            if (!in_val[s] && src_q[s].size() > 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
               in_val[s] = 1'b1;
               in_dat[s] = src_q[s][0].dat;
               in_ctl[s] = src_q[s][0].ctl;
               in_mod[s] = src_q[s][0].mod;
               in_sop[s] = src_q[s][0].sop;
               in_eop[s] = src_q[s][0].eop;
               in_err[s] = src_q[s][0].err;
            end
         end
         out_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         acc  = in_val & in_rdy;
         fire = out_val & out_rdy;
         ob   = {out_dat, out_ctl, out_mod, out_sop, out_eop, out_err};
         tick();
         cyc++;
         for (int s = 0; s < nsrc; s++) begin
            if (acc[s]) begin
               void'(src_q[s].pop_front());
               in_val[s] = 1'b0;
            end
         end
         if (fire) begin
            src = int'(ob.ctl[1:0]);
            if (in_pkt) check("no_interleave", 64'(src), 64'(cur_src));
            n_chk++;
            if (exp_q[src].size() == 0) begin
               n_fail++;
               $display("FAIL extra_beat: got beat from input %0d with none expected", src);
            end else begin
               eb = exp_q[src].pop_front();
               if (ob !== eb) begin
                  n_fail++;
                  $display("FAIL beat_src%0d: got %h expected %h", src, ob, eb);
               end
            end
            if (ob.sop) begin
               order_q.push_back(src);
               if (!rnd && last_eop >= 0) check("bubble_gap", 64'(cyc - last_eop), 64'd2);
            end
            cur_src = src;
            in_pkt  = !ob.eop;
            if (ob.eop) last_eop = cyc;
            got++;
         end
      end
      if (cyc >= 20000) check("traffic_timeout", 64'(got), 64'(total));
      check("beat_count", 64'(got), 64'(total));
      for (int s = 0; s < nsrc; s++) check("leftover", 64'(exp_q[s].size()), 64'd0);
      clear_inputs();
      out_rdy = 1'b1;
   endtask

   initial begin
      vec_t v;
      // rst val sop eop dat ordy chk | rdy val grant locked dat ctl
      tbl = '{
         '{1'b0, 4'b0100, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b1, 8'h00, 8'h00},
         '{1'b0, 4'b0100, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 8'h13, 8'hA2},
         '{1'b0, 4'b0100, 1'b0, 1'b0, 8'h22, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 8'h24, 8'hA2},
         '{1'b0, 4'b0100, 1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0, 8'h35, 8'hA2},
         '{1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b0, 8'h00, 8'h00},
         '{1'b0, 4'b0011, 1'b1, 1'b0, 8'h40, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 8'h00, 8'h00},
         '{1'b0, 4'b0011, 1'b1, 1'b0, 8'h40, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 8'h40, 8'hA0},
         '{1'b0, 4'b0011, 1'b0, 1'b1, 8'h50, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b1, 8'h40, 8'hA0},
         '{1'b0, 4'b0011, 1'b0, 1'b1, 8'h50, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 8'h50, 8'hA0},
         '{1'b0, 4'b0011, 1'b1, 1'b1, 8'h60, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1, 8'h00, 8'h00},
         '{1'b0, 4'b0011, 1'b1, 1'b1, 8'h60, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 8'h61, 8'hA1},
         '{1'b0, 4'b0001, 1'b1, 1'b0, 8'h70, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 8'h00, 8'h00},
         '{1'b0, 4'b0001, 1'b1, 1'b0, 8'h80, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 8'h80, 8'hA0},
         '{1'b1, 4'b0001, 1'b0, 1'b0, 8'h81, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00, 8'h00},
         '{1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00, 8'h00},
         '{1'b0, 4'b1010, 1'b1, 1'b1, 8'h90, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1, 8'h00, 8'h00},
         '{1'b0, 4'b1010, 1'b1, 1'b1, 8'h90, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 8'h91, 8'hA1},
         '{1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b0, 8'h00, 8'h00}
      };

      reset_dut(1'b1);
      for (int r = 0; r < 18; r++) begin
         v = tbl[r];
         rst     = v.rst;
         in_val  = v.val;
         out_rdy = v.ordy;
         for (int k = 0; k < 4; k++) begin
            in_dat[k] = {56'h0, v.dat + 8'(k)};
            in_ctl[k] = 8'hA0;
            in_mod[k] = 3'd5;
            in_sop[k] = v.sop;
            in_eop[k] = v.eop;
            in_err[k] = 1'b0;
         end
         #1;
         if (v.chk_rdy) check($sformatf("row%0d_rdy", r), 64'(in_rdy), 64'(v.exp_rdy));
         tick();
         check($sformatf("row%0d_val", r), 64'(out_val), 64'(v.exp_val));
         check($sformatf("row%0d_grant", r), 64'(grant), 64'(v.exp_grant));
         check($sformatf("row%0d_locked", r), 64'(locked), 64'(v.exp_locked));
         if (v.exp_val) begin
            check($sformatf("row%0d_dat", r), out_dat, {56'h0, v.exp_dat});
            check($sformatf("row%0d_ctl", r), 64'(out_ctl), 64'(v.exp_ctl));
            check($sformatf("row%0d_mod", r), 64'(out_mod), 64'd5);
         end
      end
      rst = 1'b0;

      // Granted input stalls mid-packet: the lock holds and input 0 waits for eop
      reset_dut(1'b0);
      out_rdy = 1'b1;
      in_val[1] = 1'b1; in_sop[1] = 1'b1; in_eop[1] = 1'b0; in_dat[1] = 64'h10;
      tick();
      check("stall_grant", 64'(grant), 64'd1);
      check("stall_locked", 64'(locked), 64'd1);
      #1;
      check("stall_rdy1", 64'(in_rdy), 64'b0010);
      tick();
      for (int i = 0; i < 5; i++) begin
         in_val[1] = 1'b0;
         in_val[0] = 1'b1; in_sop[0] = 1'b1; in_eop[0] = 1'b1; in_dat[0] = 64'hC0FFEE;
         #1;
         check("stall_rdy0_low", 64'(in_rdy[0]), 64'd0);
         tick();
         check("stall_hold_lock", 64'({locked, grant}), 64'({1'b1, 2'd1}));
      end
      in_val[1] = 1'b1; in_sop[1] = 1'b0; in_eop[1] = 1'b1; in_dat[1] = 64'h11;
      #1;
      check("stall_eop_rdy", 64'(in_rdy), 64'b0010);
      tick();
      check("stall_release", 64'(locked), 64'd0);
      in_val[1] = 1'b0;
      #1;
      check("stall_bubble_rdy", 64'(in_rdy), 64'd0);
      tick();
      check("stall_next_grant", 64'({locked, grant}), 64'({1'b1, 2'd0}));
      #1;
      check("stall_next_rdy", 64'(in_rdy), 64'b0001);
      tick();
      check("stall_next_out", 64'({out_val, out_dat}), {1'b1, 64'hC0FFEE});

      // Mid-packet reset drops the beat, the lock, and the rotation pointer
      reset_dut(1'b0);
      out_rdy = 1'b1;
      in_val[3] = 1'b1; in_sop[3] = 1'b1; in_dat[3] = 64'h31;
      tick();
      #1; tick();
      in_sop[3] = 1'b0; in_dat[3] = 64'h32;
      #1; tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      in_val = 4'b1010; in_sop = 4'b1010; in_eop = 4'b1010;
      #1;
      check("mrst_rdy", 64'(in_rdy), 64'd0);
      check("mrst_out", 64'({out_val, locked, grant}), 64'd0);
      tick();
      check("mrst_ptr0_winner", 64'({locked, grant}), 64'({1'b1, 2'd1}));
      clear_inputs();

      // All four inputs request continuously: strict rotation with one bubble per packet
      reset_dut(1'b0);
      run_traffic(4, 2, 1'b0);
      check("rr_count", 64'(order_q.size()), 64'd8);
      for (int i = 0; i < order_q.size() && i < 8; i++)
         check($sformatf("rr_order%0d", i), 64'(order_q[i]), 64'(i % 4));

      // Random lengths, gaps and output backpressure across three inputs
      reset_dut(1'b0);
      run_traffic(3, 34, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
